// File: rtl/demux_seq_pkg.sv
// demux_select_sequencer shared types and constants.
// Holds the FSM encoding and the HOLD_CYCLES legality check.
package demux_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic bit hold_ok(input int h);
    return (h >= HOLD_MIN) && (h <= HOLD_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Rotating-start priority finder over eight requests.
// Searches upward from start, wrapping mod 8; first set bit wins.
module rr_arbiter8
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  logic [IDX_W-1:0] c;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = start + IDX_W'(k);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/demux_select_sequencer.sv
// Arbitrates eight requests and drives demux selects and strobe.
// `ROUND_ROBIN_EN selects rotating priority; default is fixed.
module demux_select_sequencer
  import demux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_CH-1:0] req,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             d,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             done
);

  if (!hold_ok(HOLD_CYCLES)) begin : g_hold_bad
    $error("HOLD_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] sel, sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             d_n, busy_n, done_n;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr, ptr_n;
  assign start = ptr;
`else
  assign start = '0;
`endif

  rr_arbiter8 u_arb (
    .req   (req),
    .start (start),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    d_n     = 1'b0;
    done_n  = 1'b0;
`ifdef ROUND_ROBIN_EN
    ptr_n   = ptr;
`endif
    unique case (state)
      IDLE: begin
        if (arb_found) begin
          state_n = SETUP;
          sel_n   = arb_idx;
        end
      end
      SETUP: begin
        state_n = DRIVE;
        cnt_n   = CNT_LOAD;
        d_n     = 1'b1;
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_n = GAP;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
          d_n   = 1'b1;
        end
      end
      GAP: begin
        state_n = IDLE;
`ifdef ROUND_ROBIN_EN
        ptr_n   = sel + 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Outputs are computed for the next state so they all come from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      d     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      d     <= d_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef ROUND_ROBIN_EN
      ptr   <= ptr_n;
`endif
    end
  end

  assign s0        = sel[2];
  assign s1        = sel[1];
  assign s2        = sel[0];
  assign grant_idx = sel;

endmodule
